bit_entry_sequencer: RTL and testbench
======================================

# bit_entry_sequencer

Front-end controller for the overlapping sequence detector. It turns the two asynchronous push-button levels `input_0` and `input_1` into an ordered serial bit stream. Each press is synchronized, edge-detected, arbitrated and queued. The queued bits are then presented one at a time over a valid/ready handshake to the Mealy FSM detector. It replaces direct button-to-detector wiring, so no press is lost or duplicated while the detector stalls.

## Interface
- `FIFO_DEPTH`, 4: number of queued bits; must be ≥2.
- `SYNC_STAGES`, 2: synchronizer flops per button input; must be ≥2.
- `BIT_COUNT_W`, 8: width of the emitted-bit counter.

- `clk_1H`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `input_0`  in  1  async button level requesting a `0` bit.
- `input_1`  in  1  async button level requesting a `1` bit.
- `bit_out`  out  1  bit presented to the detector.
- `bit_valid`  out  1  `bit_out` is valid.
- `bit_ready`  in  1  detector accepts `bit_out` this cycle.
- `conflict`  out  1  one-cycle pulse: both buttons' rising edges were detected in the same cycle.
- `overflow`  out  1  one-cycle pulse: a press was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of bits queued, excluding the bit held in the output register.
- `bit_count`  out  BIT_COUNT_W  total handshakes completed; wraps to 0.

## Operation
- **Synchronizers:** each input passes through a `SYNC_STAGES` flop chain, followed by a previous-value flop. The rising edge is `sync_last & ~prev`. A held level produces exactly one edge.
- **Arbitration, evaluated per cycle:**
  - edge0 only → push `0`.
  - edge1 only → push `1`.
  - both → no push, and `conflict`=1 for one cycle.
  - neither → idle.
- **Push when full:** accepted only if a pop happens in the same cycle. Otherwise the push is dropped and `overflow`=1 for one cycle.
- **Output FSM states:**
  - EMPTY: `bit_valid`=0.
  - PRESENT: `bit_valid`=1.
- **Output FSM transitions:**
  - EMPTY → PRESENT when the FIFO is non-empty. The FIFO pops and the bit is loaded into the output register.
  - PRESENT and `bit_ready`=1, FIFO non-empty → stay in PRESENT and load the next bit, giving back-to-back transfers at one bit per cycle.
  - PRESENT and `bit_ready`=1, FIFO empty → EMPTY.
  - PRESENT and `bit_ready`=0 → hold. `bit_out` stays stable.
- **Bit counter:** `bit_count` increments on every `bit_valid & bit_ready`. After 2^BIT_COUNT_W−1 it wraps to 0.
- **Ordering:** bits are delivered strictly in press order. A press whose edge lands in the same cycle as a pop is enqueued behind the bits already in the FIFO.

## Timing
- **Reset values:** all outputs 0. Synchronizers, prev flops and FIFO pointers are cleared, and the FSM enters EMPTY.
- **Button held across reset release:** produces one press after release. This is intended.
- **Reset mid-operation:**
  - queued bits and the presented bit are discarded.
  - `bit_valid`=0 from the reset edge.
  - `bit_count` returns to 0.
- **Press latency:** input sampled high at edge N → FIFO write at edge N+SYNC_STAGES → `bit_valid`=1 after edge N+SYNC_STAGES+1. This assumes the FSM is in EMPTY and the FIFO is empty.
- **Throughput:** with `bit_ready` tied to 1, the FIFO drains at one bit per cycle.
- **Output registering:** `conflict` and `overflow` are registered in the cycle of the event and are high for exactly one cycle.
- **`fifo_count` update:** registered. It changes on the edge after a push or pop, and is unchanged on a simultaneous push and pop.
- **Input assumption:** button pulses must be at least `SYNC_STAGES`+1 cycles high and low to be counted. Shorter pulses may be missed; this is not flagged.

## Structure
- **Package `bit_entry_pkg`:**
  - output FSM state enum (EMPTY, PRESENT).
  - default `FIFO_DEPTH`, `SYNC_STAGES` and `BIT_COUNT_W` constants.
- **Sub-module `sync_fifo`:** 1-bit wide, `FIFO_DEPTH` entries, with push, pop, full, empty and count. Full and empty are derived from a wrap-bit pointer compare. Synchronizers, arbitration and the FSM stay in the top level.

## Test plan
- **Single press:** `input_1` pulsed high for 4 cycles, `bit_ready`=1 → one `bit_valid` cycle with `bit_out`=1 after edge N+3; `bit_count`=1.
- **Sequence:** presses 1,0,1,1 with `bit_ready`=1 → bits 1,0,1,1 emitted in order; `bit_count`=4; `conflict` and `overflow` never asserted.
- **Stall and overflow:** `bit_ready`=0, six `input_0` presses → first bit held in the output register; `fifo_count`=4; `overflow` pulses exactly once, on the sixth press. Releasing ready then gives 5 back-to-back bits.
- **Simultaneous press:** `input_0` and `input_1` rising on the same cycle → `conflict`=1 for one cycle; `fifo_count` stays 0; no `bit_valid`.
- **Reset mid-operation:** 3 bits queued with `bit_ready`=0, then `rst` held for 1 cycle → `bit_valid`=0, `fifo_count`=0 and `bit_count`=0 after the edge; no stale bits appear afterwards.
- **Counter wrap:** 256 accepted bits → `bit_count` reads 255, then 0.

Source files
------------

// File: rtl/bit_entry_sequencer_pkg.sv
// Shared types and default parameters for the button-to-bitstream front end.
package bit_entry_pkg;

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } out_state_t;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_BIT_COUNT_W = 8;

endpackage

// File: rtl/bit_entry_sequencer_sync_fifo.sv
// 1-bit wide synchronous FIFO; full/empty from wrap-bit pointer compare.
// DEPTH must be a power of two for the wrap-bit scheme to hold.
module sync_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      diff;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign diff  = wr_ptr - rd_ptr;
  assign count = CW'(diff);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // On full with a pop, the old entry is read out before being overwritten.
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/bit_entry_sequencer.sv
// Synchronizes two button levels, arbitrates their rising edges into a bit queue,
// and presents queued bits one at a time over valid/ready.
module bit_entry_sequencer
  import bit_entry_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int BIT_COUNT_W = DEF_BIT_COUNT_W
) (
  input  logic                             clk_1H,
  input  logic                             rst,
  input  logic                             input_0,
  input  logic                             input_1,
  output logic                             bit_out,
  output logic                             bit_valid,
  input  logic                             bit_ready,
  output logic                             conflict,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic [BIT_COUNT_W-1:0]           bit_count
);

  localparam logic [BIT_COUNT_W-1:0] CNT_ONE = 1;

  logic [SYNC_STAGES-1:0] sync0;
  logic [SYNC_STAGES-1:0] sync1;
  logic                   prev0;
  logic                   prev1;
  logic                   edge0;
  logic                   edge1;
  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  out_state_t             state;

  always_ff @(posedge clk_1H) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
      prev0 <= 1'b0;
      prev1 <= 1'b0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], input_0};
      sync1 <= {sync1[SYNC_STAGES-2:0], input_1};
      prev0 <= sync0[SYNC_STAGES-1];
      prev1 <= sync1[SYNC_STAGES-1];
    end
  end

  assign edge0    = sync0[SYNC_STAGES-1] & ~prev0;
  assign edge1    = sync1[SYNC_STAGES-1] & ~prev1;
  assign push_req = edge0 ^ edge1;
  assign pop      = ~fifo_empty & ((state == EMPTY) | bit_ready);
  // A push into a full queue survives only if the same cycle frees a slot.
  assign push     = push_req & (~fifo_full | pop);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_1H),
    .rst   (rst),
    .push  (push),
    .din   (edge1),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_1H) begin
    if (rst) begin
      state     <= EMPTY;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      conflict  <= 1'b0;
      overflow  <= 1'b0;
      bit_count <= '0;
    end else begin
      conflict <= edge0 & edge1;
      overflow <= push_req & fifo_full & ~pop;
      if (bit_valid && bit_ready) begin
        bit_count <= bit_count + CNT_ONE;
      end
      case (state)
        EMPTY: begin
          if (!fifo_empty) begin
            state     <= PRESENT;
            bit_valid <= 1'b1;
            bit_out   <= fifo_dout;
          end
        end
        PRESENT: begin
          if (bit_ready) begin
            if (!fifo_empty) begin
              bit_out <= fifo_dout;
            end else begin
              state     <= EMPTY;
              bit_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          bit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_entry_sequencer.sv
// Directed bench for bit_entry_sequencer with default parameters.
module tb_bit_entry_sequencer;

  logic       clk_1H = 1'b0;
  logic       rst = 1'b1;
  logic       input_0 = 1'b0;
  logic       input_1 = 1'b0;
  logic       bit_ready = 1'b0;
  logic       bit_out;
  logic       bit_valid;
  logic       conflict;
  logic       overflow;
  logic [2:0] fifo_count;
  logic [7:0] bit_count;

  int checks = 0;
  int errors = 0;

  int valid_cycles = 0;
  int conf_cnt = 0;
  int ovf_cnt = 0;
  bit cap[$];

  bit_entry_sequencer dut (
    .clk_1H     (clk_1H),
    .rst        (rst),
    .input_0    (input_0),
    .input_1    (input_1),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .conflict   (conflict),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .bit_count  (bit_count)
  );

  always #5 clk_1H = ~clk_1H;

  always @(negedge clk_1H) begin
    if (!rst) begin
      if (bit_valid && bit_ready) cap.push_back(bit_out);
      if (bit_valid) valid_cycles++;
      if (conflict) conf_cnt++;
      if (overflow) ovf_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1H);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic press(input bit b);
    if (b) input_1 = 1'b1;
    else input_0 = 1'b1;
    step(4);
    input_0 = 1'b0;
    input_1 = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bit_ready = 1'b1;
    step(3);
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %0b expected 0", bit_valid); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %0b expected 0", bit_out); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %0b expected 0", conflict); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    checks++; if (bit_count !== 8'd0) begin errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
    rst = 1'b0;
  endtask

  task automatic test_single_press();
    int v0;
    do_reset();
    bit_ready = 1'b1;
    v0 = valid_cycles;
    input_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid[%0d]: got %0b expected 0", k, bit_valid); end
    end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_fifo_write: got %0d expected 1", fifo_count); end
    step(1);
    checks++; if (bit_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", bit_valid); end
    checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL single_bit_out: got %0b expected 1", bit_out); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_fifo_pop: got %0d expected 0", fifo_count); end
    input_1 = 1'b0;
    step(1);
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %0b expected 0", bit_valid); end
    checks++; if (bit_count !== 8'd1) begin errors++; $display("FAIL single_bit_count: got %0d expected 1", bit_count); end
    step(6);
    checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles - v0); end
  endtask

  task automatic test_sequence();
    bit seq[4];
    int c0, oc, cc;
    seq = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    bit_ready = 1'b1;
    c0 = cap.size();
    oc = ovf_cnt;
    cc = conf_cnt;
    for (int i = 0; i < 4; i++) press(seq[i]);
    step(6);
    checks++; if (cap.size() - c0 !== 4) begin errors++; $display("FAIL seq_len: got %0d expected 4", cap.size() - c0); end
    for (int i = 0; i < 4; i++) begin
      if (c0 + i < cap.size()) begin
        checks++; if (cap[c0+i] !== seq[i]) begin errors++; $display("FAIL seq_bit[%0d]: got %0b expected %0b", i, cap[c0+i], seq[i]); end
      end
    end
    checks++; if (bit_count !== 8'd4) begin errors++; $display("FAIL seq_bit_count: got %0d expected 4", bit_count); end
    checks++; if (ovf_cnt - oc !== 0) begin errors++; $display("FAIL seq_overflow: got %0d expected 0", ovf_cnt - oc); end
    checks++; if (conf_cnt - cc !== 0) begin errors++; $display("FAIL seq_conflict: got %0d expected 0", conf_cnt - cc); end
  endtask

  task automatic test_stall_overflow();
    int oc, c0, n;
    do_reset();
    bit_ready = 1'b0;
    oc = ovf_cnt;
    for (int i = 0; i < 5; i++) press(1'b0);
    checks++; if (ovf_cnt - oc !== 0) begin errors++; $display("FAIL stall_early_overflow: got %0d expected 0", ovf_cnt - oc); end
    press(1'b0);
    checks++; if (ovf_cnt - oc !== 1) begin errors++; $display("FAIL stall_overflow: got %0d expected 1", ovf_cnt - oc); end
    checks++; if (bit_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b expected 1", bit_valid); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL stall_bit_out: got %0b expected 0", bit_out); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL stall_fifo_count: got %0d expected 4", fifo_count); end
    c0 = cap.size();
    bit_ready = 1'b1;
    n = 0;
    while (bit_valid && n < 10) begin
      n++;
      step(1);
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL stall_burst_len: got %0d expected 5", n); end
    checks++; if (bit_count !== 8'd5) begin errors++; $display("FAIL stall_bit_count: got %0d expected 5", bit_count); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL stall_drained: got %0d expected 0", fifo_count); end
    checks++; if (cap.size() - c0 !== 5) begin errors++; $display("FAIL stall_captured: got %0d expected 5", cap.size() - c0); end
    for (int i = c0; i < cap.size(); i++) begin
      checks++; if (cap[i] !== 1'b0) begin errors++; $display("FAIL stall_bit[%0d]: got %0b expected 0", i - c0, cap[i]); end
    end
  endtask

  task automatic test_simultaneous();
    int v0, cc;
    do_reset();
    bit_ready = 1'b1;
    v0 = valid_cycles;
    cc = conf_cnt;
    input_0 = 1'b1;
    input_1 = 1'b1;
    step(4);
    input_0 = 1'b0;
    input_1 = 1'b0;
    step(6);
    checks++; if (conf_cnt - cc !== 1) begin errors++; $display("FAIL simul_conflict_cycles: got %0d expected 1", conf_cnt - cc); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL simul_fifo_count: got %0d expected 0", fifo_count); end
    checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL simul_valid: got %0d expected 0", valid_cycles - v0); end
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    bit_ready = 1'b1;
    press(1'b1);
    checks++; if (bit_count !== 8'd1) begin errors++; $display("FAIL mid_pre_count: got %0d expected 1", bit_count); end
    bit_ready = 1'b0;
    press(1'b0);
    press(1'b1);
    press(1'b1);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL mid_queued: got %0d expected 2", fifo_count); end
    rst = 1'b1;
    step(1);
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", bit_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_fifo_count: got %0d expected 0", fifo_count); end
    checks++; if (bit_count !== 8'd0) begin errors++; $display("FAIL mid_bit_count: got %0d expected 0", bit_count); end
    rst = 1'b0;
    bit_ready = 1'b1;
    v0 = valid_cycles;
    step(10);
    checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL mid_stale: got %0d expected 0", valid_cycles - v0); end
    press(1'b0);
    step(2);
    checks++; if (bit_count !== 8'd1) begin errors++; $display("FAIL mid_post_count: got %0d expected 1", bit_count); end
    if (cap.size() > 0) begin
      checks++; if (cap[cap.size()-1] !== 1'b0) begin errors++; $display("FAIL mid_post_bit: got %0b expected 0", cap[cap.size()-1]); end
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    bit_ready = 1'b1;
    repeat (255) press(1'b1);
    step(2);
    checks++; if (bit_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", bit_count); end
    press(1'b1);
    step(2);
    checks++; if (bit_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", bit_count); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_sequence();
    test_stall_overflow();
    test_simultaneous();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
